// File: rtl/mem_dump_scanner.sv
// Sweeps a word window of ROM/RAM once per frame and republishes each word
// as an atomically updated MEM_Addr/MEM_Data pair for the VGA debug buffer.
module mem_dump_scanner #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned WORDS     = 128,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        VSYNC,
  input  logic        SWO13,
  output logic        mem_req,
  output logic        mem_sel,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] MEM_Addr,
  output logic [31:0] MEM_Data,
  output logic        busy,
  output logic        done
);

  localparam int unsigned IDX_W  = 7;
  localparam int unsigned TCNT_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PAD_W  = DATA_W - IDX_W - 2;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [TCNT_W-1:0] TMO_LAST = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_PUBLISH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                vs_s1_q, vs_s2_q, vs_d_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                sel_q, sel_d;
  logic [DATA_W-1:0]   rbuf_q, rbuf_d;
  logic                mem_req_q, mem_req_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   pub_addr_q, pub_addr_d;
  logic [DATA_W-1:0]   pub_data_q, pub_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                start_c;
  logic                last_word_c;
  logic                tmo_hit_c;

  assign start_c     = vs_d_q & ~vs_s2_q;
  assign last_word_c = (idx_q == LAST_IDX);
  assign tmo_hit_c   = (tcnt_q == TMO_LAST);

  // VSYNC synchronizer and falling-edge history
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_s1_q <= 1'b0;
      vs_s2_q <= 1'b0;
      vs_d_q  <= 1'b0;
    end else begin
      vs_s1_q <= VSYNC;
      vs_s2_q <= vs_s1_q;
      vs_d_q  <= vs_s2_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_c) state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_ack || tmo_hit_c) state_d = S_PUBLISH;
      end
      S_PUBLISH: begin
        state_d = last_word_c ? S_IDLE : S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    idx_d      = idx_q;
    tcnt_d     = tcnt_q;
    sel_d      = sel_q;
    rbuf_d     = rbuf_q;
    pub_addr_d = pub_addr_q;
    pub_data_d = pub_data_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_c) begin
          sel_d  = SWO13;
          idx_d  = '0;
          tcnt_d = '0;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          rbuf_d = mem_rdata;
        end else if (tmo_hit_c) begin
          rbuf_d = '0;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      S_PUBLISH: begin
        // Address and data move together so the negedge capture never tears
        pub_addr_d = {PAD_W'(0), idx_q, 2'b00};
        pub_data_d = rbuf_q;
        if (last_word_c) begin
          done_d = 1'b1;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          tcnt_d = '0;
        end
      end
      default: begin
        idx_d  = '0;
        tcnt_d = '0;
      end
    endcase

    // Request and address track the upcoming state so they are valid with it
    mem_req_d  = (state_d == S_REQ);
    busy_d     = (state_d != S_IDLE);
    mem_addr_d = BASE_ADDR + {PAD_W'(0), idx_d, 2'b00};
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q      <= '0;
      tcnt_q     <= '0;
      sel_q      <= 1'b0;
      rbuf_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= BASE_ADDR;
      pub_addr_q <= '0;
      pub_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      tcnt_q     <= tcnt_d;
      sel_q      <= sel_d;
      rbuf_q     <= rbuf_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      pub_addr_q <= pub_addr_d;
      pub_data_q <= pub_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_sel  = sel_q;
  assign mem_addr = mem_addr_q;
  assign MEM_Addr = pub_addr_q;
  assign MEM_Data = pub_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mem_dump_scanner.sv
// Scoreboard bench for mem_dump_scanner: a memory model pushes the expected
// publish when each request starts, a monitor pops it when the DUT publishes.
module tb_mem_dump_scanner;

  localparam logic [31:0] BASE_A  = 32'h0000_1000;
  localparam logic [31:0] ROM_W0  = 32'hA500_0000;
  localparam logic [31:0] RAM_W0  = 32'h5A00_0000;
  localparam int          TMO     = 15;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // ---------------- DUT A: 128-word window at 0x1000 ----------------
  logic        rstn_a = 1'b0, vsync_a = 1'b1, swo_a = 1'b0;
  logic        req_a, sel_a, ack_a, busy_a, done_a;
  logic [31:0] addr_a, rdata_a, pa_a, pd_a;

  int wait_n = 0;
  int no_ack = -1;
  int wcnt   = 0;
  logic [31:0] off_a;
  logic [6:0]  widx_a;

  assign off_a   = addr_a - BASE_A;
  assign widx_a  = off_a[8:2];
  assign ack_a   = req_a && (wcnt >= wait_n) && (int'(widx_a) != no_ack);
  assign rdata_a = (sel_a ? RAM_W0 : ROM_W0) + {25'b0, widx_a};

  always @(posedge clk) begin
    if (!req_a || ack_a) wcnt <= 0;
    else                 wcnt <= wcnt + 1;
  end

  mem_dump_scanner #(.BASE_ADDR(BASE_A), .WORDS(128), .TIMEOUT(TMO)) dut_a (
    .clk(clk), .rstn(rstn_a), .VSYNC(vsync_a), .SWO13(swo_a),
    .mem_req(req_a), .mem_sel(sel_a), .mem_addr(addr_a),
    .mem_ack(ack_a), .mem_rdata(rdata_a),
    .MEM_Addr(pa_a), .MEM_Data(pd_a), .busy(busy_a), .done(done_a)
  );

  // ---------------- DUT B: single-word window ----------------
  logic        rstn_b = 1'b0, vsync_b = 1'b1, swo_b = 1'b0;
  logic        req_b, sel_b, ack_b, busy_b, done_b;
  logic [31:0] addr_b, rdata_b, pa_b, pd_b;

  assign ack_b   = req_b;
  assign rdata_b = 32'hC0DE_0000 + addr_b;

  mem_dump_scanner #(.BASE_ADDR(32'h0), .WORDS(1), .TIMEOUT(TMO)) dut_b (
    .clk(clk), .rstn(rstn_b), .VSYNC(vsync_b), .SWO13(swo_b),
    .mem_req(req_b), .mem_sel(sel_b), .mem_addr(addr_b),
    .mem_ack(ack_b), .mem_rdata(rdata_b),
    .MEM_Addr(pa_b), .MEM_Data(pd_b), .busy(busy_b), .done(done_b)
  );

  // ---------------- Stimulus side: push expectations on each request ----------------
  exp_t        sb[$];
  int          exp_idx      = 0;
  logic        exp_sel      = 1'b0;
  logic        prev_req     = 1'b0;
  logic        fall_pending = 1'b0;
  int          fall_cyc     = 0;
  int          first_req    = 0;
  logic [31:0] cur_addr     = '0;

  always @(negedge clk) begin
    if (!rstn_a) begin
      prev_req = 1'b0;
    end else begin
      if (req_a && !prev_req) begin
        exp_t e;
        if (exp_idx == 0) begin
          first_req = cyc;
          if (fall_pending) chk("start_latency", 32'(cyc - fall_cyc), 32'd3);
          fall_pending = 1'b0;
        end
        cur_addr = BASE_A + 32'(exp_idx * 4);
        chk("req_addr", addr_a, cur_addr);
        chk("req_sel", {31'b0, sel_a}, {31'b0, exp_sel});
        e.a = 32'(exp_idx * 4);
        if (exp_idx == no_ack) begin
          e.d = 32'h0;
          e.c = cyc + TMO + 1;
        end else begin
          e.d = (exp_sel ? RAM_W0 : ROM_W0) + 32'(exp_idx);
          e.c = cyc + wait_n + 2;
        end
        sb.push_back(e);
        exp_idx++;
      end else if (req_a) begin
        chk("req_addr_stable", addr_a, cur_addr);
      end
      prev_req = req_a;
    end
  end

  // ---------------- Monitor: pop on each publish ----------------
  logic pend     = 1'b0;
  int   done_cnt = 0;
  int   done_cyc = 0;

  always @(negedge clk) begin
    if (!rstn_a) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_publish: addr %h data %h with empty scoreboard", pa_a, pd_a);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pub_addr", pa_a, e.a);
          chk("pub_data", pd_a, e.d);
          chk("pub_cycle", 32'(cyc), 32'(e.c));
        end
      end
      pend = busy_a && !req_a;
      if (done_a) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", {31'b0, busy_a}, 32'd0);
      end
    end
  end

  // ---------------- Helpers ----------------
  task automatic fall_a();
    @(negedge clk);
    vsync_a      = 1'b0;
    fall_cyc     = cyc;
    fall_pending = 1'b1;
  endtask

  task automatic rise_a();
    @(negedge clk);
    vsync_a = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_done_a(input int budget, input string nm);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("FAIL %s: no done within %0d cycles", nm, budget);
    end
  endtask

  task automatic sweep_a(input logic sel, input int wn, input int na,
                         input int dur, input string nm);
    swo_a   = sel;
    exp_sel = sel;
    wait_n  = wn;
    no_ack  = na;
    exp_idx = 0;
    fall_a();
    wait_done_a(dur + 100, nm);
    @(posedge clk);
    chk({nm, "_duration"}, 32'(done_cyc - first_req), 32'(dur));
    chk({nm, "_words"}, 32'(exp_idx), 32'd128);
    chk({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
    rise_a();
  endtask

  // ---------------- Main sequence ----------------
  initial begin
    int d0;
    int n;
    int r;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", {31'b0, req_a}, 32'd0);
    chk("rst_sel", {31'b0, sel_a}, 32'd0);
    chk("rst_addr", addr_a, BASE_A);
    chk("rst_pub_addr", pa_a, 32'd0);
    chk("rst_pub_data", pd_a, 32'd0);
    chk("rst_busy", {31'b0, busy_a}, 32'd0);
    chk("rst_done", {31'b0, done_a}, 32'd0);
    @(negedge clk);
    rstn_a = 1'b1;
    rstn_b = 1'b1;
    repeat (6) @(negedge clk);

    // Zero-wait ROM sweep
    sweep_a(1'b0, 0, -1, 256, "zero_wait");
    chk("zero_wait_last_addr", pa_a, 32'h0000_01FC);
    chk("zero_wait_last_data", pd_a, ROM_W0 + 32'h7F);

    // RAM sweep with ack on the third request cycle
    sweep_a(1'b1, 2, -1, 512, "wait_states");

    // Word 5 never acknowledged
    sweep_a(1'b0, 0, 5, 127 * 2 + TMO + 1, "timeout");
    chk("timeout_last_addr", pa_a, 32'h0000_01FC);

    // Second fall and SWO13 toggle mid-sweep are ignored
    d0      = done_cnt;
    swo_a   = 1'b1;
    exp_sel = 1'b1;
    wait_n  = 0;
    no_ack  = -1;
    exp_idx = 0;
    fall_a();
    repeat (30) @(negedge clk);
    vsync_a = 1'b1;
    swo_a   = 1'b0;
    repeat (5) @(negedge clk);
    vsync_a = 1'b0;
    repeat (5) @(negedge clk);
    swo_a   = 1'b1;
    repeat (5) @(negedge clk);
    swo_a   = 1'b0;
    wait_done_a(400, "ignored_events");
    repeat (30) @(negedge clk);
    chk("ignored_single_done", 32'(done_cnt - d0), 32'd1);
    chk("ignored_idle_req", {31'b0, req_a}, 32'd0);
    chk("ignored_words", 32'(exp_idx), 32'd128);
    rise_a();

    // New sweep after done; reset at word 40
    exp_sel = 1'b0;
    exp_idx = 0;
    fall_a();
    n = 0;
    while (exp_idx < 41 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("reset_reach_word40", 32'(exp_idx), 32'd41);
    #2;
    rstn_a = 1'b0;
    #1;
    chk("midrst_req", {31'b0, req_a}, 32'd0);
    chk("midrst_busy", {31'b0, busy_a}, 32'd0);
    chk("midrst_pub_addr", pa_a, 32'd0);
    chk("midrst_pub_data", pd_a, 32'd0);
    chk("midrst_addr", addr_a, BASE_A);
    chk("midrst_done", {31'b0, done_a}, 32'd0);
    sb.delete();
    exp_idx      = 0;
    fall_pending = 1'b0;
    repeat (3) @(negedge clk);
    rstn_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_idle_req", {31'b0, req_a}, 32'd0);
    end
    chk("post_rst_idle_busy", {31'b0, busy_a}, 32'd0);
    chk("post_rst_no_expect", 32'(exp_idx), 32'd0);
    rise_a();
    sweep_a(1'b0, 0, -1, 256, "post_reset");

    // Single-word window
    @(negedge clk);
    vsync_b = 1'b0;
    n = 0;
    while (!req_b && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("w1_req_seen", {31'b0, req_b}, 32'd1);
    r = cyc;
    chk("w1_req_addr", addr_b, 32'h0);
    n = 0;
    while (!done_b && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("w1_done_seen", {31'b0, done_b}, 32'd1);
    chk("w1_done_cycle", 32'(cyc - r), 32'd2);
    chk("w1_pub_addr", pa_b, 32'h0);
    chk("w1_pub_data", pd_b, 32'hC0DE_0000);
    chk("w1_busy", {31'b0, busy_b}, 32'd0);
    @(negedge clk);
    chk("w1_done_pulse", {31'b0, done_b}, 32'd0);
    chk("w1_no_restart", {31'b0, req_b}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
